muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_unit.sv | 169 ++++++++++++++++
 tb/tb_muldiv_unit.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit: shift-add multiply, restoring divide, one bit per cycle.
// Define MULDIV_SIGNED_EN to let op[0] select signed operation; otherwise everything is unsigned.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIX = 2'd2} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] bm_q, bm_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             is_div_q, is_div_d;
    logic             done_q, done_d;

    logic             accept;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [WIDTH-1:0] fix_hi, fix_lo;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic             div_ge;
    logic [WIDTH-1:0] div_diff;

    assign accept = (state_q == IDLE) && start;

    // Multiply step: {acc, quo} shifts right, adding the multiplicand when the low bit is set.
    assign mul_sum   = {1'b0, acc_q} + {1'b0, (quo_q[0] ? bm_q : '0)};
    // Divide step: remainder shifts in the next dividend bit and keeps the difference if non-negative.
    assign div_shift = {acc_q, quo_q[WIDTH-1]};
    assign div_ge    = (div_shift >= {1'b0, bm_q});
    assign div_diff  = div_shift[WIDTH-1:0] - bm_q;

`ifdef MULDIV_SIGNED_EN
    logic sgn_a, sgn_b;
    logic neg_q, sa_q;

    assign sgn_a = op[0] & a[WIDTH-1];
    assign sgn_b = op[0] & b[WIDTH-1];
    assign mag_a = sgn_a ? (~a + 1'b1) : a;
    assign mag_b = sgn_b ? (~b + 1'b1) : b;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            neg_q <= 1'b0;
            sa_q  <= 1'b0;
        end else if (accept) begin
            neg_q <= sgn_a ^ sgn_b;
            sa_q  <= sgn_a;
        end
    end

    // Remainder follows the dividend sign; a zero divisor always yields an all-ones quotient.
    always_comb begin
        fix_hi = acc_q;
        fix_lo = quo_q;
        if (!is_div_q) begin
            if (neg_q) {fix_hi, fix_lo} = ~{acc_q, quo_q} + 1'b1;
        end else begin
            if (sa_q) fix_hi = ~acc_q + 1'b1;
            if (bm_q == '0) fix_lo = '1;
            else if (neg_q) fix_lo = ~quo_q + 1'b1;
        end
    end
`else
    logic unused_op0;

    assign unused_op0 = op[0];
    assign mag_a      = a;
    assign mag_b      = b;
    assign fix_hi     = acc_q;
    assign fix_lo     = quo_q;
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        quo_d    = quo_q;
        bm_d     = bm_q;
        is_div_d = is_div_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = RUN;
                    cnt_d    = CNT_INIT;
                    acc_d    = '0;
                    is_div_d = op[1];
                    quo_d    = op[1] ? mag_a : mag_b;
                    bm_d     = op[1] ? mag_b : mag_a;
                end else begin
                    if (mthi) hi_d = wdata;
                    if (mtlo) lo_d = wdata;
                end
            end
            RUN: begin
                if (is_div_q) begin
                    acc_d = div_ge ? div_diff : div_shift[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], div_ge};
                end else begin
                    acc_d = mul_sum[WIDTH:1];
                    quo_d = {mul_sum[0], quo_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) state_d = FIX;
            end
            FIX: begin
                hi_d    = fix_hi;
                lo_d    = fix_lo;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            quo_q    <= '0;
            bm_q     <= '0;
            is_div_q <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            quo_q    <= quo_d;
            bm_q     <= bm_d;
            is_div_q <= is_div_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed testbench for muldiv_unit (WIDTH = 32); expectations follow MULDIV_SIGNED_EN.
module tb_muldiv_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [1:0]   op = 2'b00;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         mthi = 1'b0;
    logic         mtlo = 1'b0;
    logic [W-1:0] wdata = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .mthi  (mthi),
        .mtlo  (mtlo),
        .wdata (wdata),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    // Pulses start for one edge (edge 0); returns 1 ns after that edge.
    task automatic launch(input logic [1:0] o, input logic [W-1:0] xa, input logic [W-1:0] xb);
        op = o; a = xa; b = xb; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Counts edges after edge 0 until done rises (bounded); flags busy drop or hi/lo motion before it.
    task automatic wait_done(output int n, output bit stable);
        logic [W-1:0] hi0, lo0;
        hi0 = hi; lo0 = lo;
        n = 0; stable = 1'b1;
        while (done !== 1'b1 && n < 40) begin
            if (hi !== hi0 || lo !== lo0 || busy !== 1'b1) stable = 1'b0;
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (hi !== 32'h0) begin errors++; $display("FAIL reset_hi got %h want 00000000", hi); end
        checks++; if (lo !== 32'h0) begin errors++; $display("FAIL reset_lo got %h want 00000000", lo); end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_multu();
        int n; bit stable;
        launch(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL multu_busy_c1 got %b want 1", busy); end
        wait_done(n, stable);
        checks++; if (n != 33) begin errors++; $display("FAIL multu_latency got %0d want 33", n); end
        checks++; if (!stable) begin errors++; $display("FAIL multu_run_hold got changed want held"); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL multu_busy_done got %b want 0", busy); end
        checks++; if (hi !== 32'hFFFFFFFE) begin errors++; $display("FAIL multu_hi got %h want FFFFFFFE", hi); end
        checks++; if (lo !== 32'h00000001) begin errors++; $display("FAIL multu_lo got %h want 00000001", lo); end
        @(posedge clk); #1;
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL multu_done_width got %b want 0", done); end
    endtask

    task automatic test_signed();
        int n; bit stable;
        logic [W-1:0] ehi, elo;
`ifdef MULDIV_SIGNED_EN
        ehi = 32'hFFFFFFFF; elo = 32'hFFFFFFF1;
`else
        ehi = 32'h00000004; elo = 32'hFFFFFFF1;
`endif
        launch(2'b01, 32'hFFFFFFFD, 32'h00000005);
        wait_done(n, stable);
        checks++; if (n != 33) begin errors++; $display("FAIL mult_latency got %0d want 33", n); end
        checks++; if (hi !== ehi) begin errors++; $display("FAIL mult_hi got %h want %h", hi, ehi); end
        checks++; if (lo !== elo) begin errors++; $display("FAIL mult_lo got %h want %h", lo, elo); end
`ifdef MULDIV_SIGNED_EN
        ehi = 32'hFFFFFFFF; elo = 32'hFFFFFFFD;
`else
        ehi = 32'h00000001; elo = 32'h7FFFFFFC;
`endif
        launch(2'b11, 32'hFFFFFFF9, 32'h00000002);
        wait_done(n, stable);
        checks++; if (n != 33) begin errors++; $display("FAIL div_latency got %0d want 33", n); end
        checks++; if (hi !== ehi) begin errors++; $display("FAIL div_hi got %h want %h", hi, ehi); end
        checks++; if (lo !== elo) begin errors++; $display("FAIL div_lo got %h want %h", lo, elo); end
    endtask

    task automatic test_divide();
        int n; bit stable;
        launch(2'b10, 32'd100, 32'd7);
        wait_done(n, stable);
        checks++; if (lo !== 32'h0000000E) begin errors++; $display("FAIL divu_lo got %h want 0000000E", lo); end
        checks++; if (hi !== 32'h00000002) begin errors++; $display("FAIL divu_hi got %h want 00000002", hi); end
        launch(2'b10, 32'h00000064, 32'h00000000);
        wait_done(n, stable);
        checks++; if (n != 33) begin errors++; $display("FAIL divz_latency got %0d want 33", n); end
        checks++; if (lo !== 32'hFFFFFFFF) begin errors++; $display("FAIL divz_lo got %h want FFFFFFFF", lo); end
        checks++; if (hi !== 32'h00000064) begin errors++; $display("FAIL divz_hi got %h want 00000064", hi); end
        launch(2'b11, 32'hFFFFFFF9, 32'h00000000);
        wait_done(n, stable);
        checks++; if (lo !== 32'hFFFFFFFF) begin errors++; $display("FAIL sdivz_lo got %h want FFFFFFFF", lo); end
        checks++; if (hi !== 32'hFFFFFFF9) begin errors++; $display("FAIL sdivz_hi got %h want FFFFFFF9", hi); end
    endtask

    task automatic test_overflow();
        int n; bit stable;
        logic [W-1:0] ehi, elo;
`ifdef MULDIV_SIGNED_EN
        ehi = 32'h00000000; elo = 32'h80000000;
`else
        ehi = 32'h80000000; elo = 32'h00000000;
`endif
        launch(2'b11, 32'h80000000, 32'hFFFFFFFF);
        wait_done(n, stable);
        checks++; if (n != 33) begin errors++; $display("FAIL ovf_latency got %0d want 33", n); end
        checks++; if (lo !== elo) begin errors++; $display("FAIL ovf_lo got %h want %h", lo, elo); end
        checks++; if (hi !== ehi) begin errors++; $display("FAIL ovf_hi got %h want %h", hi, ehi); end
    endtask

    task automatic test_move();
        int n; bit stable;
        mtlo = 1'b1; wdata = 32'h12345678;
        @(posedge clk); #1; mtlo = 1'b0;
        checks++; if (lo !== 32'h12345678) begin errors++; $display("FAIL mtlo got %h want 12345678", lo); end
        mthi = 1'b1; wdata = 32'hCAFEBABE;
        @(posedge clk); #1; mthi = 1'b0;
        checks++; if (hi !== 32'hCAFEBABE) begin errors++; $display("FAIL mthi got %h want CAFEBABE", hi); end
        checks++; if (lo !== 32'h12345678) begin errors++; $display("FAIL mthi_lo_kept got %h want 12345678", lo); end
        mthi = 1'b1; mtlo = 1'b1; wdata = 32'h0F0F0F0F;
        @(posedge clk); #1; mthi = 1'b0; mtlo = 1'b0;
        checks++; if (hi !== 32'h0F0F0F0F) begin errors++; $display("FAIL mtboth_hi got %h want 0F0F0F0F", hi); end
        checks++; if (lo !== 32'h0F0F0F0F) begin errors++; $display("FAIL mtboth_lo got %h want 0F0F0F0F", lo); end
        mthi = 1'b1; wdata = 32'hFFFF0000;
        launch(2'b00, 32'd3, 32'd4);
        mthi = 1'b0;
        checks++; if (hi !== 32'h0F0F0F0F) begin errors++; $display("FAIL start_prio_hi got %h want 0F0F0F0F", hi); end
        wait_done(n, stable);
        checks++; if (!stable) begin errors++; $display("FAIL start_prio_hold got changed want held"); end
        checks++; if (lo !== 32'h0000000C) begin errors++; $display("FAIL start_prio_lo got %h want 0000000C", lo); end
        checks++; if (hi !== 32'h00000000) begin errors++; $display("FAIL start_prio_res_hi got %h want 00000000", hi); end
    endtask

    task automatic test_back_to_back();
        int n; bit stable;
        launch(2'b00, 32'd6, 32'd7);
        wait_done(n, stable);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL b2b_first_done got %b want 1", done); end
        checks++; if (lo !== 32'h0000002A) begin errors++; $display("FAIL b2b_first_lo got %h want 0000002A", lo); end
        launch(2'b10, 32'd100, 32'd10);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy got %b want 1", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL b2b_done_drop got %b want 0", done); end
        wait_done(n, stable);
        checks++; if (n != 33) begin errors++; $display("FAIL b2b_latency got %0d want 33", n); end
        checks++; if (lo !== 32'h0000000A) begin errors++; $display("FAIL b2b_lo got %h want 0000000A", lo); end
        checks++; if (hi !== 32'h00000000) begin errors++; $display("FAIL b2b_hi got %h want 00000000", hi); end
    endtask

    task automatic test_abort();
        int n; bit stable; bit quiet;
        mthi = 1'b1; wdata = 32'h11112222;
        @(posedge clk); #1; mthi = 1'b0;
        launch(2'b00, 32'd3, 32'd4);
        repeat (4) begin @(posedge clk); #1; end
        start = 1'b1; op = 2'b10; mthi = 1'b1; wdata = 32'hAAAA5555;
        @(posedge clk); #1;
        start = 1'b0; mthi = 1'b0;
        checks++; if (hi !== 32'h11112222) begin errors++; $display("FAIL busy_mthi got %h want 11112222", hi); end
        repeat (4) begin @(posedge clk); #1; end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_busy_pre got %b want 1", busy); end
        checks++; if (hi !== 32'h11112222) begin errors++; $display("FAIL abort_hi_pre got %h want 11112222", hi); end
        #2; reset = 1'b1; #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL async_busy got %b want 0", busy); end
        checks++; if (hi !== 32'h0) begin errors++; $display("FAIL async_hi got %h want 00000000", hi); end
        checks++; if (lo !== 32'h0) begin errors++; $display("FAIL async_lo got %h want 00000000", lo); end
        @(posedge clk); #1; reset = 1'b0;
        quiet = 1'b1;
        repeat (40) begin
            @(posedge clk); #1;
            if (done !== 1'b0 || busy !== 1'b0) quiet = 1'b0;
        end
        checks++; if (!quiet) begin errors++; $display("FAIL abort_quiet got activity want idle"); end
        launch(2'b10, 32'd100, 32'd7);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL post_reset_busy got %b want 1", busy); end
        wait_done(n, stable);
        checks++; if (n != 33) begin errors++; $display("FAIL post_reset_latency got %0d want 33", n); end
        checks++; if (lo !== 32'h0000000E) begin errors++; $display("FAIL post_reset_lo got %h want 0000000E", lo); end
        checks++; if (hi !== 32'h00000002) begin errors++; $display("FAIL post_reset_hi got %h want 00000002", hi); end
    endtask

    initial begin
        test_reset();
        test_multu();
        test_signed();
        test_divide();
        test_overflow();
        test_move();
        test_back_to_back();
        test_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
